uart_tx_scheduler: RTL and testbench

- Sequences the UART transmit datapath (11-bit PISO plus baud decoder) and shares it between two byte requesters: port 0 for PicoBlaze writes and port 1 for a hardware message source.
- Round-robin arbitrates, builds the 11-bit frame from the 8-bit byte and the live format switches, issues a one-cycle load, and holds baud Start until Done.
- Adds an optional inter-frame gap and a watchdog on Done.

---
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// UART transmit scheduler: round-robin shares one PISO/baud pair between two byte
// requesters, builds the 11-bit frame, and guards Done with an optional watchdog.
module uart_tx_scheduler #(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_bit8,
  input  logic        cfg_par_en,
  input  logic        cfg_par_odd,
  input  logic        req0,
  input  logic [7:0]  data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  data1,
  output logic        ack1,
  output logic [10:0] tx_frame,
  output logic        tx_ld,
  output logic        tx_busy,
  input  logic        tx_done,
  output logic [1:0]  grant,
  output logic        txrdy,
  output logic        err_timeout,
  input  logic        err_clr
);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, GAP} state_t;

  typedef struct packed {
    logic bit8;
    logic par_en;
    logic par_odd;
  } fmt_t;

  state_t           state, state_nxt;
  logic [10:0]      frame_nxt;
  logic [1:0]       grant_nxt;
  logic             ack0_nxt, ack1_nxt, ld_nxt, busy_nxt, txrdy_nxt, err_nxt;
  logic             rr, rr_nxt, pick1, to_hit;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  fmt_t             fmt;

  assign fmt = '{bit8: cfg_bit8, par_en: cfg_par_en, par_odd: cfg_par_odd};

  // Frame is {stop/parity/d7 pair, d[6:0], start 0, idle 1}; LSB leaves first.
  function automatic logic [10:0] build_frame(input logic [7:0] d, input fmt_t f);
    logic       p7, p8;
    logic [1:0] top;
    p7 = (^d[6:0]) ^ f.par_odd;
    p8 = (^d) ^ f.par_odd;
    if (f.bit8) top = {(f.par_en ? p8 : 1'b1), d[7]};
    else        top = {1'b1, (f.par_en ? p7 : 1'b1)};
    return {top, d[6:0], 2'b01};
  endfunction

  always_comb begin
    state_nxt = state;
    frame_nxt = tx_frame;
    grant_nxt = grant;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    ld_nxt    = 1'b0;
    busy_nxt  = tx_busy;
    txrdy_nxt = txrdy;
    rr_nxt    = rr;
    wd_nxt    = wd_cnt;
    gap_nxt   = gap_cnt;
    to_hit    = 1'b0;
    // rr holds the last served index; on a tie the other one wins
    pick1     = req1 & (~req0 | ~rr);
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          frame_nxt = build_frame(pick1 ? data1 : data0, fmt);
          grant_nxt = pick1 ? 2'b10 : 2'b01;
          ack0_nxt  = ~pick1;
          ack1_nxt  = pick1;
          ld_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          txrdy_nxt = 1'b0;
          rr_nxt    = pick1;
          wd_nxt    = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = BUSY;
      BUSY: begin
        if (tx_done) begin
          busy_nxt  = 1'b0;
          grant_nxt = 2'b00;
          if (GAP_CYCLES > 0) begin
            gap_nxt   = '0;
            state_nxt = GAP;
          end else begin
            txrdy_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST)) begin
          to_hit    = 1'b1;
          busy_nxt  = 1'b0;
          grant_nxt = 2'b00;
          txrdy_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          txrdy_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // clear beats a same-cycle timeout
    err_nxt = err_clr ? 1'b0 : (to_hit | err_timeout);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_frame    <= 11'h7FF;
      grant       <= 2'b00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      tx_ld       <= 1'b0;
      tx_busy     <= 1'b0;
      txrdy       <= 1'b1;
      err_timeout <= 1'b0;
      rr          <= 1'b1;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      tx_frame    <= frame_nxt;
      grant       <= grant_nxt;
      ack0        <= ack0_nxt;
      ack1        <= ack1_nxt;
      tx_ld       <= ld_nxt;
      tx_busy     <= busy_nxt;
      txrdy       <= txrdy_nxt;
      err_timeout <= err_nxt;
      rr          <= rr_nxt;
      wd_cnt      <= wd_nxt;
      gap_cnt     <= gap_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Bench for uart_tx_scheduler: format vector table, arbitration, watchdog, gap and
// reset sequences, then randomized traffic against a transaction-level model.
`define CHK(n, a, e) chk(n, 32'(a), 32'(e))
module tb_uart_tx_scheduler;
  localparam int TO    = 50;
  localparam int GAP_B = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_bit8, cfg_par_en, cfg_par_odd, req0, req1, tx_done, err_clr;
  logic [7:0]  data0, data1;
  logic        a_ack0, a_ack1, a_ld, a_busy, a_txrdy, a_err;
  logic [10:0] a_frame;
  logic [1:0]  a_grant;
  logic        b_ack0, b_ack1, b_ld, b_busy, b_txrdy, b_err;
  logic [10:0] b_frame;
  logic [1:0]  b_grant;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .reset(reset), .cfg_bit8(cfg_bit8), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .req0(req0), .data0(data0), .ack0(a_ack0),
    .req1(req1), .data1(data1), .ack1(a_ack1), .tx_frame(a_frame), .tx_ld(a_ld),
    .tx_busy(a_busy), .tx_done(tx_done), .grant(a_grant), .txrdy(a_txrdy),
    .err_timeout(a_err), .err_clr(err_clr));

  uart_tx_scheduler #(.GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .cfg_bit8(cfg_bit8), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .req0(req0), .data0(data0), .ack0(b_ack0),
    .req1(req1), .data1(data1), .ack1(b_ack1), .tx_frame(b_frame), .tx_ld(b_ld),
    .tx_busy(b_busy), .tx_done(tx_done), .grant(b_grant), .txrdy(b_txrdy),
    .err_timeout(b_err), .err_clr(err_clr));

  typedef struct {
    logic        port;
    logic [7:0]  d;
    logic        b8, pe, po;
    logic [10:0] exp;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
    data0 = 8'h00; data1 = 8'h00; cfg_bit8 = 1'b1; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  // Parity from a ones count: even parity bit = ones odd, odd parity bit = ones even.
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic b8, pe, po);
    int          ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < (b8 ? 8 : 7); i++) if (d[i]) ones++;
    f = '1;
    f[1] = 1'b0;
    for (int i = 0; i < 7; i++) f[2+i] = d[i];
    if (b8) f[9] = d[7];
    if (pe) f[b8 ? 10 : 9] = po ? (ones % 2 == 0) : (ones % 2 == 1);
    return f;
  endfunction

  initial begin
    #200us;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench timeout");
  end

  logic pr0, pr1, pb8, ppe, ppo, pdone, free, loadp, last, win, owner, seen;
  logic [7:0] pd0, pd1;
  int cd, n;

  initial begin
    vt[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 11'h695};
    vt[1] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 11'h61D};
    vt[2] = '{1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 11'h41D};
    vt[3] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 11'h7FD};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 11'h001};
    vt[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 11'h601};
    vt[6] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 11'h755};
    vt[7] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 11'h4F1};

    // reset state
    do_reset();
    reset = 1'b0;
    #2;
    `CHK("rst_frame", a_frame, 11'h7FF);
    total++;
    if (a_frame !== 11'h7FF) begin
      bad++;
      $display("FAIL rst_frame_direct: got %0h want 7ff", a_frame);
    end
    `CHK("rst_ld", a_ld, 1'b0);
    `CHK("rst_busy", a_busy, 1'b0);
    `CHK("rst_ack", {a_ack1, a_ack0}, 2'b00);
    `CHK("rst_err", a_err, 1'b0);
    `CHK("rst_grant", a_grant, 2'b00);
    `CHK("rst_txrdy", a_txrdy, 1'b1);
    reset = 1'b1;
    step();
    `CHK("idle_noreq_rdy", a_txrdy, 1'b1);
    `CHK("idle_noreq_ack", {a_ack1, a_ack0}, 2'b00);

    // format vectors; cfg/data flip and an ignored tx_done during LOAD
    for (int i = 0; i < 8; i++) begin
      cfg_bit8 = vt[i].b8; cfg_par_en = vt[i].pe; cfg_par_odd = vt[i].po;
      if (vt[i].port) begin req1 = 1'b1; data1 = vt[i].d; end
      else            begin req0 = 1'b1; data0 = vt[i].d; end
      step();
      `CHK($sformatf("vec%0d_ack", i), {a_ack1, a_ack0}, vt[i].port ? 2'b10 : 2'b01);
      `CHK($sformatf("vec%0d_grant", i), a_grant, vt[i].port ? 2'b10 : 2'b01);
      `CHK($sformatf("vec%0d_ld", i), a_ld, 1'b1);
      `CHK($sformatf("vec%0d_busy", i), a_busy, 1'b1);
      `CHK($sformatf("vec%0d_rdy", i), a_txrdy, 1'b0);
      `CHK($sformatf("vec%0d_frame", i), a_frame, vt[i].exp);
      total++;
      if (a_frame !== vt[i].exp) begin
        bad++;
        $display("FAIL vec%0d_frame_direct: got %0h want %0h", i, a_frame, vt[i].exp);
      end
      req0 = 1'b0; req1 = 1'b0; data0 = ~vt[i].d; data1 = ~vt[i].d;
      cfg_bit8 = ~cfg_bit8; cfg_par_odd = ~cfg_par_odd; cfg_par_en = ~cfg_par_en;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      `CHK($sformatf("vec%0d_ack_once", i), {a_ack1, a_ack0}, 2'b00);
      `CHK($sformatf("vec%0d_ld_once", i), a_ld, 1'b0);
      `CHK($sformatf("vec%0d_load_done_ign", i), a_busy, 1'b1);
      step(); step();
      `CHK($sformatf("vec%0d_hold_frame", i), a_frame, vt[i].exp);
      `CHK($sformatf("vec%0d_hold_busy", i), a_busy, 1'b1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      `CHK($sformatf("vec%0d_done_busy", i), a_busy, 1'b0);
      `CHK($sformatf("vec%0d_done_rdy", i), a_txrdy, 1'b1);
      `CHK($sformatf("vec%0d_done_grant", i), a_grant, 2'b00);
    end

    // round robin with both requesters held
    do_reset();
    data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    owner = 1'b0;
    for (int f = 0; f < 4; f++) begin
      seen = 1'b0; n = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step(); n++;
        seen = a_ack0 | a_ack1;
      end
      `CHK($sformatf("rr%0d_seen", f), seen, 1'b1);
      if (f > 0) `CHK($sformatf("rr%0d_latency", f), n, 1);
      `CHK($sformatf("rr%0d_ack", f), {a_ack1, a_ack0}, owner ? 2'b10 : 2'b01);
      `CHK($sformatf("rr%0d_grant", f), a_grant, owner ? 2'b10 : 2'b01);
      total++;
      if (a_grant !== (owner ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL rr%0d_grant_direct: got %0h", f, a_grant);
      end
      `CHK($sformatf("rr%0d_frame", f), a_frame,
           exp_frame(owner ? 8'h22 : 8'h11, 1'b1, 1'b0, 1'b0));
      step();
      `CHK($sformatf("rr%0d_one_ack", f), {a_ack1, a_ack0}, 2'b00);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      owner = ~owner;
    end

    // watchdog: 50 BUSY clocks after LOAD, then sticky flag and clear
    do_reset();
    req0 = 1'b1; data0 = 8'h5A;
    step();
    req0 = 1'b0;
    `CHK("wd_ack", a_ack0, 1'b1);
    step();
    for (int j = 0; j < TO - 1; j++) begin
      step();
      `CHK($sformatf("wd_early%0d", j), {a_err, a_busy}, 2'b01);
    end
    step();
    `CHK("wd_err", a_err, 1'b1);
    total++;
    if (a_err !== 1'b1) begin
      bad++;
      $display("FAIL wd_err_direct: got %0b want 1", a_err);
    end
    `CHK("wd_busy", a_busy, 1'b0);
    `CHK("wd_rdy", a_txrdy, 1'b1);
    `CHK("wd_grant", a_grant, 2'b00);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    `CHK("wd_idle_done_ack", {a_ack1, a_ack0}, 2'b00);
    `CHK("wd_idle_done_rdy", a_txrdy, 1'b1);
    `CHK("wd_sticky", a_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    `CHK("wd_clr", a_err, 1'b0);
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    for (int j = 0; j < TO - 1; j++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    `CHK("wd_clr_prio_err", a_err, 1'b0);
    `CHK("wd_clr_prio_busy", a_busy, 1'b0);
    step();
    `CHK("wd_clr_prio_after", a_err, 1'b0);

    // inter-frame gap on the GAP_CYCLES=4 instance, then async reset mid-BUSY
    do_reset();
    req1 = 1'b1; data1 = 8'hC3; cfg_par_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = b_ack1;
    end
    `CHK("gap_first_ack", seen, 1'b1);
    `CHK("gap_frame", b_frame, exp_frame(8'hC3, 1'b1, 1'b1, 1'b0));
    step(); step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    `CHK("gap_done_busy", b_busy, 1'b0);
    `CHK("gap_done_grant", b_grant, 2'b00);
    seen = 1'b0; n = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      `CHK($sformatf("gap_rdy%0d", n), b_txrdy, (n == GAP_B) ? 1'b1 : 1'b0);
      step(); n++;
      seen = b_ack1;
    end
    `CHK("gap_second_ack", seen, 1'b1);
    `CHK("gap_latency", n, GAP_B + 1);
    step(); step();
    `CHK("gap_busy_before_rst", b_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    `CHK("arst_frame", b_frame, 11'h7FF);
    `CHK("arst_busy", b_busy, 1'b0);
    `CHK("arst_grant", b_grant, 2'b00);
    `CHK("arst_rdy", b_txrdy, 1'b1);
    `CHK("arst_ld", b_ld, 1'b0);

    // randomized traffic on instance A against the transaction model
    do_reset();
    free = 1'b1; loadp = 1'b0; last = 1'b1; cd = 0;
    for (int c = 0; c < 800; c++) begin
      pr0 = req0; pr1 = req1; pd0 = data0; pd1 = data1;
      pb8 = cfg_bit8; ppe = cfg_par_en; ppo = cfg_par_odd; pdone = tx_done;
      step();
      if (free) begin
        if (pr0 | pr1) begin
          win = (pr0 & pr1) ? ~last : pr1;
          `CHK("rnd_ack", {a_ack1, a_ack0}, win ? 2'b10 : 2'b01);
          `CHK("rnd_grant", a_grant, win ? 2'b10 : 2'b01);
          `CHK("rnd_ld", a_ld, 1'b1);
          `CHK("rnd_rdy", a_txrdy, 1'b0);
          `CHK("rnd_frame", a_frame, exp_frame(win ? pd1 : pd0, pb8, ppe, ppo));
          last = win; free = 1'b0; loadp = 1'b1;
          cd = $urandom_range(2, 9);
        end else begin
          `CHK("rnd_idle", {a_ack1, a_ack0, a_ld, a_busy, a_txrdy}, 5'b00001);
          total++;
          if ({a_ack1, a_ack0, a_ld, a_busy, a_txrdy} !== 5'b00001) begin
            bad++;
            $display("FAIL rnd_idle_direct: cycle %0d", c);
          end
        end
      end else if (loadp) begin
        loadp = 1'b0;
        `CHK("rnd_load", {a_ack1, a_ack0, a_ld, a_busy}, 4'b0001);
      end else if (pdone) begin
        free = 1'b1;
        `CHK("rnd_done", {a_busy, a_txrdy, a_grant}, 4'b0100);
      end else begin
        `CHK("rnd_busy", {a_ack1, a_ack0, a_busy, a_txrdy}, 4'b0010);
      end
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 1) != 0);
      data0 = 8'($urandom); data1 = 8'($urandom);
      cfg_bit8 = 1'($urandom); cfg_par_en = 1'($urandom); cfg_par_odd = 1'($urandom);
      if (free) tx_done = ($urandom_range(0, 3) == 0);
      else begin
        if (cd > 0) cd--;
        tx_done = (cd == 0);
      end
    end
    `CHK("rnd_no_timeout", a_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
